// File: rtl/arm7tdmi_icache_sa.sv
// arm7tdmi_icache_sa: N-way set-associative ARM7TDMI instruction cache with
// per-set round-robin replacement, burst line fill and uncached single-beat fetch.
module arm7tdmi_icache_sa #(
   parameter int CACHE_SIZE_BYTES = 4096,
   parameter int CACHE_LINE_SIZE  = 32,
   parameter int WAYS             = 2,
   parameter int ADDR_WIDTH       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_req,
   input  logic                  cpu_thumb_mode,
   output logic [31:0]           cpu_data,
   output logic                  cpu_ready,
   output logic                  cpu_hit,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_req,
   output logic [3:0]            mem_burst_len,
   input  logic [31:0]           mem_data,
   input  logic                  mem_valid,
   input  logic                  mem_ready,
   input  logic                  cache_enable,
   input  logic                  cache_invalidate,
   input  logic                  cache_flush,
   input  logic                  cache_inv_line,
   input  logic [ADDR_WIDTH-1:0] cache_inv_addr,
   output logic [31:0]           cache_hits,
   output logic [31:0]           cache_misses,
   output logic                  cache_busy
);
   localparam int WORDS = CACHE_LINE_SIZE / 4;
   localparam int SETS  = CACHE_SIZE_BYTES / (CACHE_LINE_SIZE * WAYS);
   localparam int OFF_W = $clog2(CACHE_LINE_SIZE);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int WRD_W = OFF_W - 2;
   localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
   localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, FILL_REQ = 3'd2, FILL = 3'd3, UNC_REQ = 3'd4, UNC = 3'd5;

   logic [2:0] state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:OFF_W] inv_addr_q, inv_addr_d;
   logic thumb_q, thumb_d, cpu_ready_q, cpu_ready_d, cpu_hit_q, cpu_hit_d;
   logic pinv_q, pinv_d, pflush_q, pflush_d, pline_q, pline_d;
   logic [3:0] beat_q, beat_d;
   logic [WAY_W-1:0] victim_q, victim_d;
   logic [31:0] crit_q, crit_d, cpu_data_q, cpu_data_d, hits_q, hits_d, misses_q, misses_d;
   logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
   logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;
   logic [TAG_W-1:0] tag_q [WAYS][SETS];
   logic [31:0] data_q [WAYS][SETS][WORDS];
   logic data_we, tag_we, hit, free, unused_bits;
   logic [WAY_W-1:0] hit_way, free_way, vic;
   logic [IDX_W-1:0] idx, lidx;
   logic [TAG_W-1:0] tag, ltag;
   logic [WRD_W-1:0] word;

   assign idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
   assign tag  = addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];
   assign word = addr_q[OFF_W-1:2];
   assign lidx = inv_addr_q[OFF_W+IDX_W-1:OFF_W];
   assign ltag = inv_addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];
   assign vic  = free ? free_way : rr_q[idx];
   assign unused_bits = ^{addr_q[0], cache_inv_addr[OFF_W-1:0]};

   function automatic logic [31:0] sel(input logic [31:0] w, input logic th, input logic a1);
      return th ? {16'h0, a1 ? w[31:16] : w[15:0]} : w;
   endfunction

   // Descending scan so the lowest-index way wins for both hit and free slot
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      free = 1'b0;
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            hit = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[w][idx]) begin
            free = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      thumb_d = thumb_q;
      beat_d = beat_q;
      victim_d = victim_q;
      crit_d = crit_q;
      cpu_data_d = cpu_data_q;
      cpu_ready_d = 1'b0;
      cpu_hit_d = 1'b0;
      hits_d = hits_q;
      misses_d = misses_q;
      valid_d = valid_q;
      rr_d = rr_q;
      data_we = 1'b0;
      tag_we = 1'b0;
      pinv_d = pinv_q | cache_invalidate;
      pflush_d = pflush_q | cache_flush;
      pline_d = pline_q | cache_inv_line;
      inv_addr_d = cache_inv_line ? cache_inv_addr[ADDR_WIDTH-1:OFF_W] : inv_addr_q;
      case (state_q)
         IDLE: begin
            if (pinv_q || pflush_q) begin
               valid_d = '0;
               pinv_d = cache_invalidate;
               pflush_d = cache_flush;
               hits_d = pflush_q ? '0 : hits_q;
               misses_d = pflush_q ? '0 : misses_q;
            end else if (pline_q) begin
               for (int w = 0; w < WAYS; w++)
                  if (tag_q[w][lidx] == ltag) valid_d[w][lidx] = 1'b0;
               pline_d = cache_inv_line;
            end else if (cpu_req) begin
               addr_d = cpu_addr;
               thumb_d = cpu_thumb_mode;
               state_d = cache_enable ? LOOKUP : UNC_REQ;
            end
         end
         LOOKUP: begin
            if (hit) begin
               cpu_data_d = sel(data_q[hit_way][idx][word], thumb_q, addr_q[1]);
               cpu_ready_d = 1'b1;
               cpu_hit_d = 1'b1;
               hits_d = hits_q + 32'(hits_q != '1);
               state_d = IDLE;
            end else begin
               misses_d = misses_q + 32'(misses_q != '1);
               victim_d = vic;
               valid_d[vic][idx] = 1'b0;
               beat_d = '0;
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: state_d = mem_ready ? FILL : FILL_REQ;
         FILL: begin
            if (mem_valid) begin
               data_we = 1'b1;
               beat_d = beat_q + 4'd1;
               crit_d = beat_q == 4'(word) ? mem_data : crit_q;
               if (beat_q == 4'(WORDS - 1)) begin
                  valid_d[victim_q][idx] = 1'b1;
                  tag_we = 1'b1;
                  rr_d[idx] = WAYS > 1 ? rr_q[idx] + 1'b1 : '0;
                  cpu_ready_d = 1'b1;
                  cpu_data_d = sel(beat_q == 4'(word) ? mem_data : crit_q, thumb_q, addr_q[1]);
                  state_d = IDLE;
               end
            end
         end
         UNC_REQ: state_d = mem_ready ? UNC : UNC_REQ;
         UNC: begin
            if (mem_valid) begin
               cpu_ready_d = 1'b1;
               cpu_data_d = sel(mem_data, thumb_q, addr_q[1]);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q <= '0;
         inv_addr_q <= '0;
         thumb_q <= 1'b0;
         beat_q <= '0;
         victim_q <= '0;
         crit_q <= '0;
         cpu_data_q <= '0;
         cpu_ready_q <= 1'b0;
         cpu_hit_q <= 1'b0;
         hits_q <= '0;
         misses_q <= '0;
         valid_q <= '0;
         rr_q <= '0;
         pinv_q <= 1'b0;
         pflush_q <= 1'b0;
         pline_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         inv_addr_q <= inv_addr_d;
         thumb_q <= thumb_d;
         beat_q <= beat_d;
         victim_q <= victim_d;
         crit_q <= crit_d;
         cpu_data_q <= cpu_data_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_hit_q <= cpu_hit_d;
         hits_q <= hits_d;
         misses_q <= misses_d;
         valid_q <= valid_d;
         rr_q <= rr_d;
         pinv_q <= pinv_d;
         pflush_q <= pflush_d;
         pline_q <= pline_d;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) data_q[victim_q][idx][beat_q[WRD_W-1:0]] <= mem_data;
      if (tag_we) tag_q[victim_q][idx] <= tag;
   end

   assign cpu_data = cpu_data_q;
   assign cpu_ready = cpu_ready_q;
   assign cpu_hit = cpu_hit_q;
   assign cache_hits = hits_q;
   assign cache_misses = misses_q;
   assign mem_req = state_q == FILL_REQ || state_q == UNC_REQ;
   assign mem_addr = state_q == FILL_REQ ? {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)} :
                     state_q == UNC_REQ  ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_burst_len = state_q == FILL_REQ ? 4'(WORDS - 1) : 4'd0;
   assign cache_busy = state_q != IDLE || pinv_q || pflush_q || pline_q;
endmodule
